multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath mux/strobe controls.
//  Handshakes with a variable-latency memory (mem_ready) and has an optional timeout.
//  Counts retired instructions. Sits between the IR opcode field and the shared-memory datapath.
// PARAMETERS
//  ALUOP_W   3   width of alu_op; encodings ADD=0, SUB=1, RTYPE(funct decode)=2, zero-extended
//  CNT_W     32  width of instr_cnt; wraps modulo 2^CNT_W
//  TIMEOUT   0   max cycles waiting on mem_ready before abort; 0 = wait forever
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  op           in   6        IR[31:26]; sampled in DECODE only
//  zero         in   1        ALU zero flag; used in BRANCH
//  mem_ready    in   1        memory access complete this cycle
//  pc_write     out  1        PC load enable
//  pc_src       out  2        00 ALU result, 01 ALUOut (branch target), 10 jump target
//  ir_write     out  1        IR load enable
//  i_or_d       out  1        memory address: 0 PC, 1 ALUOut
//  mem_read     out  1        memory read request
//  mem_write    out  1        memory write request
//  mem2reg      out  1        write-back data: 0 ALUOut, 1 MDR
//  reg_dst      out  2        00 rt, 01 rd
//  reg_write    out  1        register file write enable
//  alu_src_a    out  1        0 PC, 1 rs
//  alu_src_b    out  2        00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  ALUOP_W  ALU operation class
//  retire       out  1        one-cycle pulse in the last cycle of each legal instruction
//  illegal      out  1        one-cycle pulse: undefined opcode seen in DECODE
//  bus_err      out  1        one-cycle pulse: memory timeout abort
//  instr_cnt    out  CNT_W    retired-instruction count
//  state        out  4        current state, debug
// BEHAVIOUR
//  States: IDLE0 FETCH1 DECODE2 MADDR3 MREAD4 MWB5 MWRITE6 REXEC7 RWB8 BRANCH9 JUMP10 AEXEC11 AWB12.
//  Reset: state=IDLE, instr_cnt=0. Every output except state/instr_cnt is 0 in IDLE. IDLE->FETCH always.
//  Outputs are Moore decodes of state. pc_write and ir_write are additionally qualified by inputs as below.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
//    Holds while mem_ready=0. When mem_ready=1: pc_write=ir_write=1, next DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target -> ALUOut). Dispatch on op:
//    000000->REXEC  100011/101011->MADDR  000100->BRANCH  000010->JUMP  001000->AEXEC
//    any other: illegal=1, next FETCH, no retire, no count.
//  MADDR: alu_src_a=1, alu_src_b=10, ADD. Next MREAD for lw, MWRITE for sw.
//    The lw/sw choice uses the op latched in DECODE in an internal register; the live op input is not used.
//  MREAD: mem_read=1, i_or_d=1. Holds until mem_ready, then MWB.
//  MWB: reg_write=1, mem2reg=1, reg_dst=00, retire=1, next FETCH.
//  MWRITE: mem_write=1, i_or_d=1. Holds until mem_ready; on mem_ready: retire=1, next FETCH.
//  REXEC: alu_src_a=1, alu_src_b=00, alu_op=RTYPE, next RWB.
//  RWB: reg_write=1, reg_dst=01, mem2reg=0, retire=1, next FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=zero, retire=1, next FETCH.
//  JUMP: pc_src=10, pc_write=1, retire=1, next FETCH.
//  AEXEC: alu_src_a=1, alu_src_b=10, ADD, next AWB.
//  AWB: reg_write=1, reg_dst=00, mem2reg=0, retire=1, next FETCH.
//  Latency: R/addi/lw-store = 4/4/5/4 cycles with zero memory wait; beq and j = 3 cycles.
//  instr_cnt increments on the clock edge that ends each retire cycle, and wraps at 2^CNT_W-1 -> 0.
//  Timeout (TIMEOUT>0): a wait counter clears on entry to FETCH/MREAD/MWRITE and counts each cycle
//    with mem_ready=0. When it reaches TIMEOUT: bus_err=1 that cycle, no strobes/retire, next FETCH.
//    mem_ready=1 in the same cycle as the limit wins, and the access completes normally.
//  Async rst mid-instruction: immediate IDLE, all strobes drop, instr_cnt=0. No partial write is completed.
//  mem_ready is ignored outside FETCH/MREAD/MWRITE. zero is ignored outside BRANCH.
// TESTING
//  1 reset then mem_ready=1 always, op=000000 -> IDLE,1,2,7,8; reg_write/reg_dst=01 in RWB; instr_cnt=1.
//  2 op=100011, mem_ready low 3 cycles in MREAD -> MREAD held 4 cycles; MWB mem2reg=1; retire once.
//  3 op=000100 zero=1 then zero=0 -> pc_write=1 pc_src=01 first time, pc_write=0 second; both retire.
//  4 op=111111 -> illegal pulse in DECODE, next FETCH, instr_cnt unchanged; op=000010 -> pc_src=10.
//  5 TIMEOUT=4, mem_ready=0 in FETCH -> bus_err on 4th wait cycle, re-enter FETCH; ready at limit -> no bus_err.
//  6 rst asserted mid MWRITE (async, between edges) -> mem_write falls at once, state=IDLE, instr_cnt=0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and drives the
// datapath selects and strobes. Memory accesses wait on mem_ready, with an
// optional timeout abort. Retired instructions are counted in instr_cnt.
module multi_cycle_ctrl #(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               ir_write,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem2reg,
   output logic [1:0]         reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               retire,
   output logic               illegal,
   output logic               bus_err,
   output logic [CNT_W-1:0]   instr_cnt,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MADDR  = 4'd3,
      MREAD  = 4'd4,
      MWB    = 4'd5,
      MWRITE = 4'd6,
      REXEC  = 4'd7,
      RWB    = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10,
      AEXEC  = 4'd11,
      AWB    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(2);

   // Wait counter only has to reach TIMEOUT-1; the limit cycle itself aborts.
   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : {WAIT_W{1'b0}};

   state_t             state_q, state_d;
   logic [5:0]         op_q, op_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
   logic               mem_wait_s;
   logic               timeout_s;

   assign mem_wait_s = (state_q == FETCH) || (state_q == MREAD) || (state_q == MWRITE);
   assign timeout_s  = (TIMEOUT > 0) && mem_wait_s && !mem_ready && (wait_cnt_q == WAIT_LAST);
   assign state      = state_q;
   assign instr_cnt  = instr_cnt_q;

   // State, latched opcode, wait counter and retire counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 6'b000000;
         wait_cnt_q  <= {WAIT_W{1'b0}};
         instr_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wait_cnt_q  <= wait_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   // Wait counter advances only while the same access keeps stalling; any exit or abort clears it.
   always_comb begin
      wait_cnt_d = {WAIT_W{1'b0}};
      if (mem_wait_s && !mem_ready && !timeout_s) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end else begin
         wait_cnt_d = {WAIT_W{1'b0}};
      end
   end

   // Retired-instruction count, wrapping naturally at the counter width.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      if (retire) begin
         instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end else begin
         instr_cnt_d = instr_cnt_q;
      end
   end

   // Next-state logic and Moore output decode (pc_write/ir_write/retire qualified by inputs).
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      ir_write  = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem2reg   = 1'b0;
      reg_dst   = 2'b00;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = ALU_ADD;
      retire    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               pc_write = 1'b1;
               ir_write = 1'b1;
               state_d  = DECODE;
            end else if (timeout_s) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            alu_src_b = 2'b11;
            op_d      = op;
            case (op)
               OP_RTYPE: state_d = REXEC;
               OP_LW:    state_d = MADDR;
               OP_SW:    state_d = MADDR;
               OP_BEQ:   state_d = BRANCH;
               OP_J:     state_d = JUMP;
               OP_ADDI:  state_d = AEXEC;
               default: begin
                  illegal = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         MADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (op_q == OP_SW) begin
               state_d = MWRITE;
            end else begin
               state_d = MREAD;
            end
         end
         MREAD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               state_d = MWB;
            end else if (timeout_s) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = MREAD;
            end
         end
         MWB: begin
            reg_write = 1'b1;
            mem2reg   = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         MWRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else if (timeout_s) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = MWRITE;
            end
         end
         REXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_RTYPE;
            state_d   = RWB;
         end
         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_write  = zero;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         AEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = AWB;
         end
         AWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus random instruction
// streams, checked cycle by cycle against an instruction-level model that
// expands each instruction into its expected phase sequence.
module tb_multi_cycle_ctrl;

   localparam int ALUOP_W = 3;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [5:0]         op;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic [1:0]         pc_src;
   logic               ir_write;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               mem2reg;
   logic [1:0]         reg_dst;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] alu_op;
   logic               retire;
   logic               illegal;
   logic               bus_err;
   logic [CNT_W-1:0]   instr_cnt;
   logic [3:0]         state;
   logic [19:0]        ctrl_obs;

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_cnt = 0;

   multi_cycle_ctrl #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .retire(retire), .illegal(illegal), .bus_err(bus_err), .instr_cnt(instr_cnt), .state(state)
   );

   always #5 clk = ~clk;

   assign ctrl_obs = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem2reg,
                      reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, retire, illegal, bus_err};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected control vector in the same bit order as ctrl_obs.
   function automatic logic [19:0] mk(input int pcw, input int pcs, input int irw, input int iod,
                                      input int mr, input int mw, input int m2r, input int rd,
                                      input int rw, input int asa, input int asb, input int aop,
                                      input int ret, input int ill, input int be);
      logic [19:0] v;
      v = {pcw[0], pcs[1:0], irw[0], iod[0], mr[0], mw[0], m2r[0], rd[1:0],
           rw[0], asa[0], asb[1:0], aop[2:0], ret[0], ill[0], be[0]};
      return v;
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive inputs, compare mid-cycle, advance the model counter on retire.
   task automatic step(input string tag, input logic [5:0] op_i, input logic z_i, input logic mr_i,
                       input int exp_st, input logic [19:0] exp_ctrl);
      op        = op_i;
      zero      = z_i;
      mem_ready = mr_i;
      @(negedge clk);
      check_eq({tag, " state"}, 32'(state), 32'(exp_st));
      check_eq({tag, " ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl));
      check_eq({tag, " cnt"}, 32'(instr_cnt), 32'(exp_cnt % (1 << CNT_W)));
      if (exp_ctrl[2]) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   // Memory-wait phase: 'waits' stall cycles then ready. Every TIMEOUT consecutive
   // stalls abort; FETCH retries the access, data accesses drop the instruction.
   task automatic mem_phase(input string tag, input int st, input int waits,
                            input logic [19:0] c_wait, input logic [19:0] c_done,
                            input logic [19:0] c_abort, input bit refetch, output bit ok);
      int run;
      run = 0;
      ok  = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            step(tag, rop(), rb(), 1'b1, st, c_done);
            ok = 1'b1;
         end else begin
            run++;
            if (run == TIMEOUT) begin
               step({tag, " timeout"}, rop(), rb(), 1'b0, st, c_abort);
               run = 0;
               if (!refetch) return;
            end else begin
               step(tag, rop(), rb(), 1'b0, st, c_wait);
            end
         end
      end
   endtask

   // One instruction from FETCH to its last cycle.
   task automatic run_instr(input logic [5:0] op_v, input logic z, input int fw, input int mw);
      bit ok;
      logic [19:0] dec_c;
      dec_c = mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0,0);
      mem_phase("fetch", 1, fw, mk(0,0,0,0,1,0,0,0,0,0,1,0,0,0,0),
                mk(1,0,1,0,1,0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,1,0,0,0,0,0,1,0,0,0,1), 1'b1, ok);
      case (op_v)
         6'b000000: begin
            step("decode", op_v, rb(), rb(), 2, dec_c);
            step("rexec", rop(), rb(), rb(), 7, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0,0));
            step("rwb", rop(), rb(), rb(), 8, mk(0,0,0,0,0,0,0,1,1,0,0,0,1,0,0));
         end
         6'b100011: begin
            step("decode", op_v, rb(), rb(), 2, dec_c);
            step("maddr", rop(), rb(), rb(), 3, mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
            mem_phase("mread", 4, mw, mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0),
                      mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0,1), 1'b0, ok);
            if (ok) step("mwb", rop(), rb(), rb(), 5, mk(0,0,0,0,0,0,1,0,1,0,0,0,1,0,0));
         end
         6'b101011: begin
            step("decode", op_v, rb(), rb(), 2, dec_c);
            step("maddr", rop(), rb(), rb(), 3, mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
            mem_phase("mwrite", 6, mw, mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0),
                      mk(0,0,0,1,0,1,0,0,0,0,0,0,1,0,0), mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0,1), 1'b0, ok);
         end
         6'b000100: begin
            step("decode", op_v, rb(), rb(), 2, dec_c);
            step("branch", rop(), z, rb(), 9, mk(int'(z),1,0,0,0,0,0,0,0,1,0,1,1,0,0));
         end
         6'b000010: begin
            step("decode", op_v, rb(), rb(), 2, dec_c);
            step("jump", rop(), rb(), rb(), 10, mk(1,2,0,0,0,0,0,0,0,0,0,0,1,0,0));
         end
         6'b001000: begin
            step("decode", op_v, rb(), rb(), 2, dec_c);
            step("aexec", rop(), rb(), rb(), 11, mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
            step("awb", rop(), rb(), rb(), 12, mk(0,0,0,0,0,0,0,0,1,0,0,0,1,0,0));
         end
         default: begin
            step("decode illegal", op_v, rb(), rb(), 2, mk(0,0,0,0,0,0,0,0,0,0,3,0,0,1,0));
         end
      endcase
   endtask

   initial begin
      logic [5:0] legal_ops [6];
      logic [5:0] rop_v;
      int fw;
      int mw;
      legal_ops[0] = 6'b000000;
      legal_ops[1] = 6'b100011;
      legal_ops[2] = 6'b101011;
      legal_ops[3] = 6'b000100;
      legal_ops[4] = 6'b000010;
      legal_ops[5] = 6'b001000;

      rst       = 1'b1;
      op        = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b0;
      #2;
      check_eq("reset state", 32'(state), 32'd0);
      check_eq("reset ctrl", 32'(ctrl_obs), 32'd0);
      check_eq("reset cnt", 32'(instr_cnt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("idle", rop(), rb(), rb(), 0, 20'd0);

      // R-type with memory always ready.
      run_instr(6'b000000, 1'b0, 0, 0);
      check_eq("rtype retired cnt", 32'(instr_cnt), 32'd1);
      // lw with three stall cycles in MREAD.
      run_instr(6'b100011, 1'b0, 0, 3);
      // beq taken then not taken.
      run_instr(6'b000100, 1'b1, 0, 0);
      run_instr(6'b000100, 1'b0, 0, 0);
      // Illegal opcode, then jump.
      run_instr(6'b111111, 1'b0, 0, 0);
      run_instr(6'b000010, 1'b0, 0, 0);
      // Timeouts: fetch abort and retry, ready exactly at the limit, data aborts.
      run_instr(6'b000000, 1'b0, 5, 0);
      run_instr(6'b001000, 1'b0, 3, 0);
      run_instr(6'b100011, 1'b0, 0, 4);
      run_instr(6'b101011, 1'b0, 0, 6);
      run_instr(6'b101011, 1'b0, 2, 3);

      // Random instruction stream; enough retires to wrap the counter several times.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            rop_v = rop();
         end else begin
            rop_v = legal_ops[$urandom_range(0, 5)];
         end
         fw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 2));
         mw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 2));
         run_instr(rop_v, rb(), fw, mw);
      end

      // Asynchronous reset in the middle of a store.
      step("rst fetch", rop(), rb(), 1'b1, 1, mk(1,0,1,0,1,0,0,0,0,0,1,0,0,0,0));
      step("rst decode", 6'b101011, rb(), rb(), 2, mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
      step("rst maddr", rop(), rb(), rb(), 3, mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
      mem_ready = 1'b0;
      @(negedge clk);
      check_eq("mwrite before rst", 32'(mem_write), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mwrite after rst", 32'(mem_write), 32'd0);
      check_eq("state after rst", 32'(state), 32'd0);
      check_eq("cnt after rst", 32'(instr_cnt), 32'd0);
      exp_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("idle again", rop(), rb(), rb(), 0, 20'd0);
      run_instr(6'b001000, 1'b0, 1, 0);
      check_eq("cnt after restart", 32'(instr_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
